// File: rtl/pipe_stage_chain.sv
// Pipeline register chain with per-stage valid bits and bubble-collapsing flow control.
//
// Stage 0 is the input stage and stage DEPTH-1 is the output stage. A stage
// loads from its upstream neighbour whenever it is empty or is emptying in the
// same cycle, so gaps in the stream close up under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   clr        synchronous flush of all stages (active high)
//   ena        global advance enable; 0 freezes the chain
//   in_valid   upstream data valid
//   in_ready   chain accepts in_data this cycle
//   in_data    upstream data
//   out_valid  output stage holds valid data
//   out_ready  downstream can accept
//   out_data   output-stage data, always driven
//   count      number of valid stages, 0..DEPTH
module pipe_stage_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             clr,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // Per-stage source (what each stage would load if it advances).
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];

  // rdy[i]: stage i can take a new value this cycle.
  logic [DEPTH:0]   rdy;

  logic             run;
  logic             accept;
  logic             emit;

  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = !valid_q[i] || rdy[i+1];
    end
  end

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  assign run       = ena && !clr;
  assign in_ready  = run && rdy[0];
  assign out_valid = run && valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  assign accept = in_ready && in_valid;
  assign emit   = out_valid && out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (clr) begin
      valid_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_d[i] = '0;
      end
      count_d = '0;
    end else if (ena) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        // A bubble still loads data; its content is don't-care.
        if (rdy[i]) begin
          valid_d[i] = src_valid[i];
          data_d[i]  = src_data[i];
        end
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(emit);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             clrn;
  logic             clr;
  logic             ena;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .clr      (clr),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clrn = 1'b0; clr = 1'b0; ena = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    tick();
    clrn = 1'b1;
    tick();

    // Reset streaming
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    #1;
    chk("s1_in_ready", 32'(in_ready), 1);
    tick();
    chk("s1_cnt1", 32'(count), 1);
    chk("s1_ov_e1", 32'(out_valid), 0);
    in_data = 8'h22;
    tick();
    chk("s1_cnt2", 32'(count), 2);
    chk("s1_ov_e2", 32'(out_valid), 0);
    in_data = 8'h33;
    tick();
    chk("s1_ov_e3", 32'(out_valid), 1);
    chk("s1_out11", 32'(out_data), 32'h11);
    chk("s1_cnt3", 32'(count), 3);
    in_valid = 1'b0;
    tick();
    chk("s1_out22", 32'(out_data), 32'h22);
    chk("s1_cnt_d2", 32'(count), 2);
    tick();
    chk("s1_out33", 32'(out_data), 32'h33);
    chk("s1_cnt_d1", 32'(count), 1);
    tick();
    chk("s1_empty_ov", 32'(out_valid), 0);
    chk("s1_empty_cnt", 32'(count), 0);

    // Backpressure fill
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
    tick();
    in_data = 8'hA1;
    tick();
    in_data = 8'hA2;
    tick();
    chk("s2_cnt_full", 32'(count), 3);
    in_data = 8'hA3;
    #1;
    chk("s2_full_in_ready", 32'(in_ready), 0);
    tick();
    chk("s2_cnt_hold", 32'(count), 3);
    chk("s2_out_a0", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    #1;
    chk("s2_pass_in_ready", 32'(in_ready), 1);
    chk("s2_pass_ov", 32'(out_valid), 1);
    tick();
    chk("s2_cnt_same", 32'(count), 3);
    chk("s2_out_a1", 32'(out_data), 32'hA1);
    in_valid = 1'b0;
    tick();
    chk("s2_out_a2", 32'(out_data), 32'hA2);
    tick();
    chk("s2_out_a3", 32'(out_data), 32'hA3);
    chk("s2_cnt_1", 32'(count), 1);
    tick();
    chk("s2_drained", 32'(count), 0);

    // Bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    chk("s3_not_yet", 32'(out_valid), 0);
    tick();
    chk("s3_ov", 32'(out_valid), 1);
    chk("s3_out_5a", 32'(out_data), 32'h5A);
    chk("s3_cnt1", 32'(count), 1);
    tick();
    chk("s3_hold_5a", 32'(out_data), 32'h5A);
    in_valid = 1'b1; in_data = 8'h6B;
    tick();
    in_data = 8'h7C;
    tick();
    chk("s3_cnt3", 32'(count), 3);
    chk("s3_still_5a", 32'(out_data), 32'h5A);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("s3_out_6b", 32'(out_data), 32'h6B);
    tick();
    chk("s3_out_7c", 32'(out_data), 32'h7C);
    tick();
    chk("s3_drained", 32'(count), 0);

    // Stall
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_data = 8'h03;
    tick();
    ena = 1'b0; in_data = 8'h99; out_ready = 1'b1;
    #1;
    chk("s4_in_ready", 32'(in_ready), 0);
    chk("s4_ov", 32'(out_valid), 0);
    repeat (4) tick();
    chk("s4_cnt", 32'(count), 3);
    chk("s4_ov_after", 32'(out_valid), 0);
    chk("s4_out_01", 32'(out_data), 32'h01);
    ena = 1'b1; in_valid = 1'b0;
    #1;
    chk("s4_resume_ov", 32'(out_valid), 1);
    chk("s4_resume_01", 32'(out_data), 32'h01);
    tick();
    chk("s4_out_02", 32'(out_data), 32'h02);
    chk("s4_cnt2", 32'(count), 2);

    // Flush (refill to full first)
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h04;
    tick();
    chk("s5_full", 32'(count), 3);
    clr = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    #1;
    chk("s5_clr_in_ready", 32'(in_ready), 0);
    chk("s5_clr_ov", 32'(out_valid), 0);
    tick();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("s5_cnt0", 32'(count), 0);
    chk("s5_ov0", 32'(out_valid), 0);
    chk("s5_data0", 32'(out_data), 0);
    chk("s5_empty_in_ready", 32'(in_ready), 1);

    // Async reset mid-stream with count=2
    in_valid = 1'b1; in_data = 8'hC1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'hC2;
    tick();
    in_valid = 1'b0;
    chk("s6_cnt2", 32'(count), 2);
    chk("s6_out_c1", 32'(out_data), 32'hC1);
    #3;
    clrn = 1'b0;
    #1;
    chk("s6_rst_cnt", 32'(count), 0);
    chk("s6_rst_ov", 32'(out_valid), 0);
    chk("s6_rst_data", 32'(out_data), 0);
    tick();
    clrn = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hD7;
    tick();
    in_valid = 1'b0;
    chk("s6_cnt_acc", 32'(count), 1);
    tick();
    chk("s6_ov_e2", 32'(out_valid), 0);
    tick();
    chk("s6_ov_e3", 32'(out_valid), 1);
    chk("s6_out_d7", 32'(out_data), 32'hD7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised multi-stage pipeline register chain: WIDTH-bit data, DEPTH stages, per-stage valid bit.
- Global stall (ena) and synchronous flush (clr).
- Bubble-collapsing valid/ready flow control: a stage accepts when it is empty or when it empties in the same cycle.
- Generalises the single-bit enable/clear flip-flop into the pipeline latch used between CPU stages and in game-logic datapaths.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- clrn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of all stages; active high.
- ena  input  1  global advance enable; 0 freezes the whole chain.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  chain can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream can accept.
- out_data  output  WIDTH  last-stage data.
- count  output  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (clrn=0, asynchronous): all valid bits = 0, all data registers = 0, count = 0. Outputs settle immediately without a clock edge. Release is synchronous to the next clk edge.
- Stage index: 0 is the input stage, DEPTH-1 is the output stage.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = ena && !clr && rdy[0].
- out_valid = ena && !clr && v[DEPTH-1].
- out_data = data[DEPTH-1], always driven.
- Output transfer occurs when out_valid && out_ready.
- Per edge when ena=1 and clr=0, for each stage i in parallel:
  - Stage 0 loads in_data and sets v[0]=in_valid if rdy[0]; otherwise it holds.
  - Stage i>0 loads data[i-1] and sets v[i]=v[i-1] if rdy[i]; otherwise it holds.
  - A bubble (v=0) entering a ready stage clears that stage's valid bit. The data register still loads, so its content is don't-care.
- ena=0: every stage holds data and valid. in_ready=0 and out_valid=0, so no transfer occurs.
- clr=1 on an edge: all v = 0 and all data = 0, regardless of ena, in_valid or out_ready. No transfer occurs in that cycle.
- Priority: clrn > clr > ena > flow control.
- Latency: DEPTH cycles from accept to out_valid when unstalled. Throughput is 1 word/cycle when out_ready stays high.
- Full: count=DEPTH and out_ready=0 gives in_ready=0.
- Full with out_ready=1: in_ready=1, so accept and emit happen in the same cycle.
- Empty: count=0 and out_valid=0; in_ready=ena && !clr.
- Bubble collapse: with out_ready=0, new words fill empty stages downstream until the chain is full. No stage is ever overwritten while valid unless it is advancing.
- count:
  - Registered; equals the popcount of v after each edge.
  - Updates as count + accept − emit; never wraps.
  - Returns to 0 on clr or clrn.
- DEPTH=1: behaves as a single-entry buffer with in_ready = ena && !clr && (!v[0] || out_ready).
- Any X on in_data is passed through unchanged; no X scrubbing is performed.

Test Plan (WIDTH=8, DEPTH=3):
- Reset streaming: clrn pulse, then in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles and out_ready=1 -> out_valid first high 3 cycles after the 0x11 accept; outputs 0x11, 0x22, 0x33 on consecutive cycles; count peaks at 3.
- Backpressure fill: out_ready=0, push 0xA0..0xA3 -> 0xA0..0xA2 accepted, in_ready=0 on the 4th word, count=3. Then out_ready=1 for one cycle -> 0xA0 emitted and 0xA3 accepted in the same cycle; count stays 3.
- Bubble collapse: single word 0x5A accepted, out_ready=0 -> 0x5A reaches stage 2 after 3 cycles and holds. Then push 0x6B and 0x7C -> both accepted, count=3, out_data=0x5A.
- Stall: chain holding 0x01/0x02/0x03, ena=0 for 4 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count=3, contents unchanged. On ena=1, 0x01 emits first.
- Flush: chain full, assert clr with in_valid=1 and out_ready=1 -> no transfer that cycle; next cycle count=0, out_valid=0, out_data=0x00.
- Async reset mid-stream: drop clrn between clock edges with count=2 -> count=0, out_valid=0, out_data=0 immediately. After release, the first accepted word emerges after 3 cycles.
